// File: rtl/one_wire_slave.sv
// 1-Wire slave core: reset/presence handling, ROM command decode (READ/SKIP/MATCH)
// against a 64-bit ROM ID, then a byte-oriented function phase (receive or transmit).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | not addressed; only a bus reset is acted on
// PRES_WAIT | reset seen, waiting before the presence pulse
// PRESENCE  | driving the presence pulse
// ROM_CMD   | shifting in the 8-bit ROM command
// ROM_READ  | sending the 64-bit ROM ID, LSB first
// ROM_MATCH | comparing 64 received bits against the ROM ID
// FN_CMD    | shifting in the 8-bit function command
// FN_RX     | receiving data bytes for local logic
// FN_TX     | sending bytes supplied by local logic
module one_wire_slave #(
  parameter int          CLKS_PER_US      = 50,
  parameter int          RESET_MIN_US     = 480,
  parameter int          PRESENCE_WAIT_US = 30,
  parameter int          PRESENCE_US      = 120,
  parameter int          SAMPLE_US        = 30,
  parameter int          TX_HOLD_US       = 45,
  parameter logic [7:0]  READ_CMD         = 8'hBE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ow_in,
  output logic        ow_out,
  output logic        ow_oe,
  input  logic [63:0] rom_id,
  output logic        selected,
  output logic [7:0]  fn_cmd,
  output logic        fn_cmd_dv,
  output logic [7:0]  rx_byte,
  output logic        rx_dv,
  output logic        byte_req,
  input  logic [7:0]  tx_byte
);

  // Timers load "length - 1" and run down to a terminal count of zero.
  localparam logic [15:0] PRESC_MAX = 16'(CLKS_PER_US - 1);
  localparam logic [15:0] WAIT_CYC  = 16'(PRESENCE_WAIT_US * CLKS_PER_US - 1);
  localparam logic [15:0] PRES_CYC  = 16'(PRESENCE_US * CLKS_PER_US - 1);
  localparam logic [15:0] HOLD_CYC  = 16'(TX_HOLD_US * CLKS_PER_US - 1);
  localparam logic [9:0]  RESET_MIN = 10'(RESET_MIN_US);
  localparam logic [9:0]  SAMPLE    = 10'(SAMPLE_US);

  typedef enum logic [3:0] {
    IDLE, PRES_WAIT, PRESENCE, ROM_CMD, ROM_READ, ROM_MATCH, FN_CMD, FN_RX, FN_TX
  } state_t;

  state_t      state, state_nx;
  logic        s1, s2, s3, fall_r, rise_r;
  logic [15:0] presc, tmr, tmr_nx, hcnt, hcnt_nx;
  logic [9:0]  low_us;
  logic        armed, pres_start;
  logic [5:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  sh, sh_nx, fn_cmd_nx, rx_nx, shift_in;
  logic        oe_nx, fn_dv_nx, rx_dv_nx, br_nx;
  logic        fall_acc, reset_ev, slot, bit_v, tx_bit;

  assign ow_out   = 1'b0;
  assign selected = (state == FN_CMD) || (state == FN_RX) || (state == FN_TX);

  // The presence pulse is our own drive, so its falling edge is not a master slot.
  assign fall_acc = fall_r && (state != PRESENCE);
  assign reset_ev = rise_r && (low_us >= RESET_MIN);
  assign slot     = rise_r && armed && !reset_ev;
  assign bit_v    = (low_us < SAMPLE);
  assign shift_in = {bit_v, sh[7:1]};
  assign tx_bit   = (state == ROM_READ) ? rom_id[bit_cnt] : sh[0];

  // Bus synchronizer plus registered edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      fall_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      s1     <= ow_in;
      s2     <= s1;
      s3     <= s2;
      fall_r <= s3 & ~s2;
      rise_r <= ~s3 & s2;
    end
  end

  // Bus-low time in microseconds; restarted by a master fall or the presence start,
  // so a reset issued during presence still measures at least the reset length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      low_us <= '0;
    end else if (fall_acc || pres_start) begin
      presc  <= '0;
      low_us <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      if (low_us != 10'h3FF) low_us <= low_us + 10'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // A rising edge is only a slot if a master falling edge opened it; this drops the
  // trailing edge of our own presence pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       armed <= 1'b0;
    else if (fall_acc)             armed <= 1'b1;
    else if (rise_r || pres_start) armed <= 1'b0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmr       <= '0;
      hcnt      <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      ow_oe     <= 1'b0;
      fn_cmd    <= '0;
      fn_cmd_dv <= 1'b0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      byte_req  <= 1'b0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      hcnt      <= hcnt_nx;
      bit_cnt   <= bit_cnt_nx;
      sh        <= sh_nx;
      ow_oe     <= oe_nx;
      fn_cmd    <= fn_cmd_nx;
      fn_cmd_dv <= fn_dv_nx;
      rx_byte   <= rx_nx;
      rx_dv     <= rx_dv_nx;
      byte_req  <= br_nx;
    end
  end

  // Next-state and next-output logic; a bus reset overrides every state.
  always_comb begin
    state_nx   = state;
    tmr_nx     = tmr;
    hcnt_nx    = hcnt;
    bit_cnt_nx = bit_cnt;
    sh_nx      = sh;
    oe_nx      = ow_oe;
    fn_cmd_nx  = fn_cmd;
    fn_dv_nx   = 1'b0;
    rx_nx      = rx_byte;
    rx_dv_nx   = 1'b0;
    br_nx      = 1'b0;
    pres_start = 1'b0;

    if (byte_req) sh_nx = tx_byte;

    case (state)
      IDLE: ;
      PRES_WAIT: begin
        if (tmr == '0) begin
          state_nx   = PRESENCE;
          tmr_nx     = PRES_CYC;
          oe_nx      = 1'b1;
          pres_start = 1'b1;
        end else tmr_nx = tmr - 16'd1;
      end
      PRESENCE: begin
        if (tmr == '0) begin
          state_nx   = ROM_CMD;
          oe_nx      = 1'b0;
          bit_cnt_nx = '0;
        end else tmr_nx = tmr - 16'd1;
      end
      ROM_CMD: begin
        if (slot) begin
          sh_nx      = shift_in;
          bit_cnt_nx = bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            bit_cnt_nx = '0;
            case (shift_in)
              8'h33:   state_nx = ROM_READ;
              8'hCC:   state_nx = FN_CMD;
              8'h55:   state_nx = ROM_MATCH;
              default: state_nx = IDLE;
            endcase
          end
        end
      end
      ROM_READ, FN_TX: begin
        // Hold time is fixed from the slot start; the bus is low throughout, so
        // no further falling edge can retrigger it.
        if (ow_oe) begin
          if (hcnt == '0) oe_nx = 1'b0;
          else            hcnt_nx = hcnt - 16'd1;
        end else if (fall_acc && !tx_bit) begin
          oe_nx   = 1'b1;
          hcnt_nx = HOLD_CYC;
        end
        if (slot) begin
          bit_cnt_nx = bit_cnt + 6'd1;
          if (state == ROM_READ) begin
            if (bit_cnt == 6'd63) begin
              state_nx   = FN_CMD;
              bit_cnt_nx = '0;
            end
          end else begin
            sh_nx = {1'b0, sh[7:1]};
            if (bit_cnt == 6'd7) begin
              bit_cnt_nx = '0;
              br_nx      = 1'b1;
            end
          end
        end
      end
      ROM_MATCH: begin
        if (slot) begin
          bit_cnt_nx = bit_cnt + 6'd1;
          if (bit_v != rom_id[bit_cnt]) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
          end else if (bit_cnt == 6'd63) begin
            state_nx   = FN_CMD;
            bit_cnt_nx = '0;
          end
        end
      end
      FN_CMD: begin
        if (slot) begin
          sh_nx      = shift_in;
          bit_cnt_nx = bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            bit_cnt_nx = '0;
            fn_cmd_nx  = shift_in;
            fn_dv_nx   = 1'b1;
            if (shift_in == READ_CMD) begin
              state_nx = FN_TX;
              br_nx    = 1'b1;
            end else state_nx = FN_RX;
          end
        end
      end
      FN_RX: begin
        if (slot) begin
          sh_nx      = shift_in;
          bit_cnt_nx = bit_cnt + 6'd1;
          if (bit_cnt == 6'd7) begin
            bit_cnt_nx = '0;
            rx_nx      = shift_in;
            rx_dv_nx   = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (reset_ev) begin
      state_nx   = PRES_WAIT;
      tmr_nx     = WAIT_CYC;
      bit_cnt_nx = '0;
      hcnt_nx    = '0;
      oe_nx      = 1'b0;
      br_nx      = 1'b0;
    end
  end

endmodule

// File: tb/tb_one_wire_slave.sv
// Directed bench for one_wire_slave acting as a simple 1-Wire master.
// Strobe outputs are checked through an expected-event queue.
module tb_one_wire_slave;
  localparam int CPU = 4;
  localparam logic [63:0] ROM = 64'h2800_0012_3456_7801;
  localparam logic [3:0] S_IDLE = 4'd0, S_ROM_CMD = 4'd3, S_ROM_MATCH = 4'd5,
                         S_FN_CMD = 4'd6, S_FN_TX = 4'd8;
  localparam logic [1:0] K_FN = 2'd0, K_RX = 2'd1, K_BR = 2'd2, K_NONE = 2'd3;

  logic clk = 1'b0, rst = 1'b1, m_low = 1'b0;
  logic ow_in, ow_out, ow_oe, selected, fn_cmd_dv, rx_dv, byte_req;
  logic [63:0] rom_id = ROM;
  logic [7:0] fn_cmd, rx_byte, tx_byte = 8'h00;

  typedef struct packed { logic [1:0] kind; logic [7:0] val; } ev_t;
  ev_t exp_q[$];
  int total = 0, bad = 0;

  assign ow_in = !(m_low || ow_oe);
  always #10 clk = ~clk;

  one_wire_slave #(.CLKS_PER_US(CPU)) dut (
    .clk(clk), .rst(rst), .ow_in(ow_in), .ow_out(ow_out), .ow_oe(ow_oe),
    .rom_id(rom_id), .selected(selected), .fn_cmd(fn_cmd), .fn_cmd_dv(fn_cmd_dv),
    .rx_byte(rx_byte), .rx_dv(rx_dv), .byte_req(byte_req), .tx_byte(tx_byte));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic chk_ev(input logic [1:0] k, input logic [7:0] v);
    ev_t e;
    e = '{kind: K_NONE, val: 8'h00};
    if (exp_q.size() != 0) e = exp_q.pop_front();
    total++;
    assert (k === e.kind && v === e.val) else begin
      bad++;
      $error("FAIL strobe observed kind=%0d val=%h expected kind=%0d val=%h", k, v, e.kind, e.val);
    end
  endtask

  // Every strobe must match the next expected event (K_NONE means none was expected).
  always @(negedge clk) begin
    if (!rst) begin
      if (fn_cmd_dv) chk_ev(K_FN, fn_cmd);
      if (rx_dv)     chk_ev(K_RX, rx_byte);
      if (byte_req)  chk_ev(K_BR, 8'h00);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic us(input int n);
    clks(n * CPU);
  endtask

  // After a master release, presence should start 30 us later (plus the 4-cycle
  // input latency) and last 120 us.
  task automatic presence(input string tag);
    int rise_k, width;
    rise_k = 0;
    width  = 0;
    for (int k = 1; k <= 200 * CPU; k++) begin
      clks(1);
      if (ow_oe) begin rise_k = k; break; end
    end
    for (int w = 1; w <= 200 * CPU; w++) begin
      clks(1);
      if (!ow_oe) begin width = w; break; end
    end
    chk_range({tag, "_pres_start"}, rise_k, 29 * CPU, 31 * CPU + 4);
    chk_range({tag, "_pres_width"}, width, 119 * CPU, 121 * CPU);
    us(5);
  endtask

  task automatic bus_reset(input string tag);
    m_low = 1'b1;
    us(500);
    m_low = 1'b0;
    presence(tag);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    if (b) begin us(2);  m_low = 1'b0; us(8); end
    else   begin us(40); m_low = 1'b0; us(5); end
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  // Read slot: 2 us master low, sample at 12 us; lat = cycles until the slave drives.
  task automatic read_bit(output logic b, output int lat);
    lat = 0;
    m_low = 1'b1;
    for (int k = 1; k <= 2 * CPU; k++) begin
      clks(1);
      if (ow_oe && lat == 0) lat = k;
    end
    m_low = 1'b0;
    us(10);
    b = ow_in;
    us(45);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    int lat;
    for (int i = 0; i < 8; i++) begin
      read_bit(b, lat);
      v[i] = b;
    end
  endtask

  initial begin
    logic [63:0] got;
    logic [7:0] rb;
    logic b;
    int lat;

    clks(3);
    chk("rst_ow_oe", ow_oe, 0);
    chk("rst_selected", selected, 0);
    chk("rst_fn_cmd", fn_cmd, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_strobes", {fn_cmd_dv, rx_dv, byte_req}, 0);
    chk("rst_state", 4'(dut.state), S_IDLE);
    chk("ow_out", ow_out, 0);
    rst = 1'b0;
    clks(3);

    // Presence after a 500 us reset.
    bus_reset("t1");
    chk("t1_state", 4'(dut.state), S_ROM_CMD);
    chk("t1_selected", selected, 0);

    // READ ROM: the ID comes back LSB first.
    bus_reset("t2");
    write_byte(8'h33);
    for (int i = 0; i < 64; i++) begin
      read_bit(b, lat);
      got[i] = b;
      if (i == 1) chk("t2_oe_latency", lat, 4);
    end
    chk("t2_rom_bits", got, ROM);
    chk("t2_state", 4'(dut.state), S_FN_CMD);
    chk("t2_selected", selected, 1);

    // MATCH ROM with the right ID, then a function command and a data byte.
    bus_reset("t3");
    write_byte(8'h55);
    for (int i = 0; i < 64; i++) write_bit(ROM[i]);
    exp_q.push_back('{kind: K_FN, val: 8'h4E});
    write_byte(8'h4E);
    exp_q.push_back('{kind: K_RX, val: 8'hA5});
    write_byte(8'hA5);
    chk("t3_pending", exp_q.size(), 0);
    chk("t3_fn_cmd", fn_cmd, 8'h4E);
    chk("t3_rx_byte", rx_byte, 8'hA5);
    chk("t3_selected", selected, 1);

    // MATCH ROM with bit 5 flipped: drops out on the 6th ID slot.
    bus_reset("t4");
    write_byte(8'h55);
    for (int i = 0; i < 5; i++) write_bit(ROM[i]);
    chk("t4_state_before", 4'(dut.state), S_ROM_MATCH);
    write_bit(!ROM[5]);
    chk("t4_state_after", 4'(dut.state), S_IDLE);
    for (int i = 6; i < 64; i++) write_bit(ROM[i]);
    write_byte(8'h4E);
    write_byte(8'hA5);
    chk("t4_pending", exp_q.size(), 0);
    chk("t4_selected", selected, 0);

    // SKIP ROM + read command: transmit two bytes; each byte boundary requests the next.
    bus_reset("t5");
    tx_byte = 8'h3C;
    write_byte(8'hCC);
    exp_q.push_back('{kind: K_FN, val: 8'hBE});
    exp_q.push_back('{kind: K_BR, val: 8'h00});
    write_byte(8'hBE);
    chk("t5_entry_req", exp_q.size(), 0);
    tx_byte = 8'h5A;
    exp_q.push_back('{kind: K_BR, val: 8'h00});
    read_byte(rb);
    chk("t5_byte0", rb, 8'h3C);
    exp_q.push_back('{kind: K_BR, val: 8'h00});
    read_byte(rb);
    chk("t5_byte1", rb, 8'h5A);
    chk("t5_pending", exp_q.size(), 0);
    chk("t5_state", 4'(dut.state), S_FN_TX);

    // Reset in the middle of a received byte: no partial byte, presence follows.
    bus_reset("t6");
    write_byte(8'hCC);
    exp_q.push_back('{kind: K_FN, val: 8'h12});
    write_byte(8'h12);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    m_low = 1'b1;
    us(600);
    m_low = 1'b0;
    presence("t6");
    chk("t6_pending", exp_q.size(), 0);
    chk("t6_state", 4'(dut.state), S_ROM_CMD);

    // Asynchronous reset while the slave holds the bus low for a 0 bit.
    bus_reset("t7");
    tx_byte = 8'h00;
    write_byte(8'hCC);
    exp_q.push_back('{kind: K_FN, val: 8'hBE});
    exp_q.push_back('{kind: K_BR, val: 8'h00});
    write_byte(8'hBE);
    m_low = 1'b1;
    us(2);
    m_low = 1'b0;
    us(5);
    chk("t7_holding", ow_oe, 1);
    rst = 1'b1;
    #1;
    chk("t7_oe_async", ow_oe, 0);
    chk("t7_sel_async", selected, 0);
    chk("t7_fn_cmd_async", fn_cmd, 0);
    chk("t7_pending", exp_q.size(), 0);
    clks(2);
    rst = 1'b0;
    clks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/one_wire_slave.md
Name: one_wire_slave

Overview:
- 1-Wire responder (slave device model) for the other end of the bus driven by the one-wire master interface.
- Detects reset pulses, answers with a presence pulse, and decodes ROM commands READ ROM, SKIP ROM and MATCH ROM against a 64-bit ROM ID.
- In the function phase it either delivers received bytes to local logic or transmits bytes that local logic supplies.
- Used as an on-chip loopback target and bench model for the master, and as a standalone slave core.

Parameters:
CLKS_PER_US, 50, clk cycles per microsecond
RESET_MIN_US, 480, minimum bus-low time decoded as reset
PRESENCE_WAIT_US, 30, delay from reset release to presence start
PRESENCE_US, 120, presence pulse length
SAMPLE_US, 30, low-time threshold: shorter = bit 1, else bit 0
TX_HOLD_US, 45, slave hold-low time when transmitting a 0
READ_CMD, 8'hBE, function command that selects transmit mode

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ow_in  in  1  raw bus level (asynchronous)
ow_out  out  1  constant 0 (open-drain data)
ow_oe  out  1  1 = pull bus low
rom_id  in  64  device ROM ID, sent and compared LSB first
selected  out  1  high while in a function-phase state
fn_cmd  out  8  last function command received
fn_cmd_dv  out  1  one-cycle strobe, fn_cmd updated
rx_byte  out  8  received function-phase data byte
rx_dv  out  1  one-cycle strobe, rx_byte updated
byte_req  out  1  one-cycle strobe at each transmit byte boundary
tx_byte  in  8  byte to transmit; sampled on the byte_req cycle

Behaviour:
- Reset values: ow_oe=0, selected=0, fn_cmd=0, fn_cmd_dv=0, rx_byte=0, rx_dv=0, byte_req=0, state=IDLE, all counters=0.
- ow_in passes through a 2-FF synchronizer. Falling and rising edges are detected on the synchronized value. Falling edges are ignored while ow_oe=1 during presence.
- Low timer:
  - On each falling edge, the microsecond prescaler (mod CLKS_PER_US) and the 10-bit low_us counter clear.
  - low_us saturates at 1023.
- Slot decode on each rising edge:
  - low_us >= RESET_MIN_US: reset event, from any state, overriding everything. Clear bit and byte counters, drop ow_oe, go to PRESENCE_WAIT.
  - Otherwise: slot bit = (low_us < SAMPLE_US). The bit is committed on this rising edge only, so a reset pulse never produces a data bit.
- States:
  - IDLE: ignore slots; wait for reset.
  - PRESENCE_WAIT: count PRESENCE_WAIT_US, then go to PRESENCE.
  - PRESENCE: ow_oe=1 for PRESENCE_US, release, then go to ROM_CMD.
  - ROM_CMD: shift 8 bits LSB first, then decode:
    - 8'h33 -> ROM_READ
    - 8'hCC -> FN_CMD
    - 8'h55 -> ROM_MATCH
    - any other value (including 8'hF0) -> IDLE
  - ROM_READ: 64 slots, bit i = rom_id[i]. For a 0 bit, ow_oe=1 from the cycle after the falling edge is detected, for TX_HOLD_US·CLKS_PER_US cycles. After the 64th slot, go to FN_CMD.
  - ROM_MATCH: 64 received bits, each compared to rom_id[i]. First mismatch -> IDLE immediately. All 64 equal -> FN_CMD.
  - FN_CMD: 8 bits, then fn_cmd updates with a fn_cmd_dv pulse in the cycle after the 8th rising edge. If fn_cmd == READ_CMD -> FN_TX, else -> FN_RX.
  - FN_RX: every 8 bits, rx_byte updates with an rx_dv pulse in the cycle after the 8th rising edge. Repeats until reset.
  - FN_TX:
    - byte_req pulses on FN_TX entry and in the cycle after every 8th slot. tx_byte loads into the shift register on that cycle.
    - Bits are driven as in ROM_READ, LSB first. Repeats until reset.
- selected=1 in FN_CMD, FN_RX and FN_TX; otherwise 0.
- Latency: ow_oe rises 4 clk cycles after the raw ow_in falling edge (2 sync + detect + register).
- A tx-0 hold is never extended past TX_HOLD_US. If a new falling edge arrives while the slave is still holding low, it is ignored.
- A reset event during PRESENCE or a tx-0 hold is still detected, since the master holds the bus ≥480 µs. Reset behaves as above.
- Asynchronous rst mid-operation returns all outputs to their reset values immediately.

Test Plan:
- Master low 500 µs, then release -> ow_oe high from 30 µs to 150 µs after release (±1 µs); state ROM_CMD; selected=0.
- Reset, then ROM 8'h33 with 64 read slots (master low 2 µs, sample at 12 µs), rom_id=64'h2800_0012_3456_7801 -> decoded bits reproduce rom_id LSB first; then FN_CMD.
- Reset, 8'h55 with matching ID, then 8'h4E, 8'hA5 -> fn_cmd_dv with fn_cmd=8'h4E; rx_dv with rx_byte=8'hA5; selected=1.
- Reset, 8'h55 with ID bit 5 flipped -> state IDLE after 6th ID slot; no fn_cmd_dv for following bytes.
- Reset, 8'hCC, 8'hBE, tx_byte=8'h3C, 16 read slots -> byte_req pulses twice; first byte decodes as 8'h3C.
- In FN_RX after 3 bits, master low 600 µs -> no rx_dv; presence follows. Also assert rst mid-slot -> ow_oe=0 immediately.
